// File: rtl/doodle_motion_engine_if.sv
// Doodle motion engine bus: keyboard/collision inputs in, sprite state out.
// master drives keycode/start/land; slave returns X/Y, velocity and game state.
interface doodle_motion_engine_if;
    logic [7:0] keycode;
    logic       start;
    logic       land;
    logic [9:0] Doodle_X_out;
    logic [9:0] Doodle_Y_out;
    logic [7:0] vel_y;
    logic [1:0] state;
    logic       dead;

    modport master (
        output keycode, start, land,
        input  Doodle_X_out, Doodle_Y_out, vel_y, state, dead
    );

    modport slave (
        input  keycode, start, land,
        output Doodle_X_out, Doodle_Y_out, vel_y, state, dead
    );
endinterface

// File: rtl/doodle_motion_engine.sv
// Doodle Jump player mover: frame-tick detect, IDLE/AIR/DEAD FSM, bounce, jump, gravity.
// Ports: Clk, Reset_n (async low), frame_clk (async raw), bus (slave) keys in / sprite out.
module doodle_motion_engine #(
    parameter int W       = 320,
    parameter int H       = 240,
    parameter int SIZE_X  = 10,
    parameter int SIZE_Y  = 10,
    parameter int X_MIN   = 80,
    parameter int X_MAX   = 239,
    parameter int Y_MIN   = 1,
    parameter int X_STEP  = 1,
    parameter int GRAVITY = 1,
    parameter int VMAX    = 10,
    parameter int JUMP_V  = 3,
    parameter int JUMP_CD = 10,
    parameter logic [7:0] KEY_L = 8'h04,
    parameter logic [7:0] KEY_R = 8'h07,
    parameter logic [7:0] KEY_J = 8'h1C
) (
    input logic                  Clk,
    input logic                  Reset_n,
    input logic                  frame_clk,
    doodle_motion_engine_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        AIR  = 2'b01,
        DEAD = 2'b10
    } state_t;

    localparam logic [9:0] X0 = 10'((W - SIZE_X) / 2);
    localparam logic [9:0] Y0 = 10'(H * 2 / 3);
    localparam logic [7:0] VY_JUMP = 8'(-JUMP_V);
    localparam logic [7:0] CD_LOAD = 8'(JUMP_CD);

    localparam logic signed [10:0] C_XSTEP = 11'(X_STEP);
    localparam logic signed [10:0] C_XMIN  = 11'(X_MIN);
    localparam logic signed [10:0] C_XHI   = 11'(X_MAX - SIZE_X);
    localparam logic signed [10:0] C_YMIN  = 11'(Y_MIN);
    localparam logic signed [10:0] C_SY    = 11'(SIZE_Y);
    localparam logic signed [10:0] C_YLIM  = 11'(H - 2);
    localparam logic signed [10:0] C_GRAV  = 11'(GRAVITY);
    localparam logic signed [10:0] C_VMAX  = 11'(VMAX);

    // fs[0],fs[1]: synchroniser; fs[2]: previous synced level for edge detect
    logic [2:0] fs;
    logic       tick;

    state_t     st_q, st_d;
    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic [7:0] vy_q, vy_d;
    logic [7:0] cd_q, cd_d;

    logic signed [10:0] x_s, y_s, vy_s;
    logic signed [10:0] xn, yn, vg;
    logic [7:0]         cd_dec;
    logic               vy_pos;

    assign tick = fs[1] & ~fs[2];

    assign x_s  = signed'({1'b0, x_q});
    assign y_s  = signed'({1'b0, y_q});
    assign vy_s = signed'({{3{vy_q[7]}}, vy_q});
    assign vy_pos = !vy_q[7] && (vy_q != 8'd0);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fs   <= 3'b000;
            st_q <= IDLE;
            x_q  <= X0;
            y_q  <= Y0;
            vy_q <= 8'd0;
            cd_q <= 8'd0;
        end else begin
            fs   <= {fs[1:0], frame_clk};
            st_q <= st_d;
            x_q  <= x_d;
            y_q  <= y_d;
            vy_q <= vy_d;
            cd_q <= cd_d;
        end
    end

    always_comb begin
        st_d = st_q;
        x_d  = x_q;
        y_d  = y_q;
        vy_d = vy_q;
        cd_d = cd_q;

        xn = x_s;
        if (bus.keycode == KEY_L) begin
            xn = x_s - C_XSTEP;
        end else if (bus.keycode == KEY_R) begin
            xn = x_s + C_XSTEP;
        end
        // horizontal wrap between the two playfield edges
        if (xn > C_XHI) begin
            xn = C_XMIN;
        end else if (xn < C_XMIN) begin
            xn = C_XHI;
        end

        yn = y_s + vy_s;

        vg = vy_s + C_GRAV;
        if (vg > C_VMAX) begin
            vg = C_VMAX;
        end

        cd_dec = (cd_q != 8'd0) ? cd_q - 8'd1 : cd_q;

        unique case (st_q)
            IDLE, DEAD: begin
                if (bus.start) begin
                    st_d = AIR;
                    x_d  = X0;
                    y_d  = Y0;
                    vy_d = VY_JUMP;
                    cd_d = 8'd0;
                end
            end
            AIR: begin
                if (tick) begin
                    if (yn < C_YMIN) begin
                        // hitting the ceiling kills all vertical speed
                        x_d  = xn[9:0];
                        y_d  = 10'(Y_MIN);
                        vy_d = 8'd0;
                        cd_d = cd_dec;
                    end else if (yn + C_SY > C_YLIM) begin
                        // fell off the bottom: freeze where we were
                        st_d = DEAD;
                    end else begin
                        x_d = xn[9:0];
                        y_d = yn[9:0];
                        if (bus.land && vy_pos) begin
                            vy_d = VY_JUMP;
                        end else if (bus.keycode == KEY_J && cd_q == 8'd0) begin
                            vy_d = VY_JUMP;
                        end else begin
                            vy_d = vg[7:0];
                        end
                        if (!(bus.land && vy_pos) && bus.keycode == KEY_J
                            && cd_q == 8'd0) begin
                            cd_d = CD_LOAD;
                        end else begin
                            cd_d = cd_dec;
                        end
                    end
                end
            end
            default: st_d = IDLE;
        endcase
    end

    assign bus.Doodle_X_out = x_q;
    assign bus.Doodle_Y_out = y_q;
    assign bus.vel_y        = vy_q;
    assign bus.state        = st_q;
    assign bus.dead         = (st_q == DEAD);

endmodule
